controle_execucao: RTL

- Multicycle sequencer for the single-issue RISC-V datapath (lw, sw, sub, xor, addi, srl, beq).
- Drives the shared 4-bit estado bus consumed by somapc, lerinstrucao, decodificacao, sinaisdecontrole, registradores, alu and memoria.
- Adds run/single-step control, opcode-dependent phase skipping, halt/illegal/timeout detection, and cycle/instruction counters for the testbench and debug.

---
 rtl/controle_execucao.sv | 206 ++++++++++++++++++++
 1 files changed

// File: rtl/controle_execucao.sv
// controle_execucao - multicycle sequencer for the single-issue RISC-V
// datapath (lw, sw, sub, xor, addi, srl, beq). Broadcasts the 4-bit phase
// code on estado, adds run/single-step control, opcode-dependent phase
// skipping, halt/illegal/watchdog detection and busy-cycle/retired counters.
//
// Ports:
//   clk          system clock, everything updates on posedge
//   rst          synchronous active-low reset
//   run          level, 1 = execute continuously
//   step         single-step request, rising edge only
//   instrucao    fetched instruction (sampled only in ID)
//   estado       phase code to the datapath
//   busy         estado is neither IDLE nor FIM
//   halted       estado is FIM
//   illegal      sticky, unsupported opcode seen in ID
//   timeout      sticky, retired-instruction watchdog expired
//   pc_write     high exactly during SUMPC
//   ciclos       saturating busy-cycle counter
//   instr_count  saturating retired-instruction counter
//
// State  | code | meaning
// IDLE   | 1010 | waiting for run or a step edge
// IF     | 0000 | instruction fetch
// ID     | 0001 | decode, opcode latched on exit
// EX     | 0010 | execute
// AUX1   | 0101 | execute settle
// AUX2   | 1111 | opcode-dependent dispatch
// MEM    | 0011 | data memory access (lw/sw)
// WB     | 0100 | register write-back
// AUX3   | 0110 | write-back settle
// AUX4   | 0111 | write-back settle
// SUMPC  | 1000 | PC update, instruction retires
// FIM    | 1001 | terminal halt, left only by reset

module controle_execucao #(
    parameter int CNT_W     = 32,
    parameter int MAX_INSTR = 1024
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             run,
    input  logic             step,
    input  logic [31:0]      instrucao,
    output logic [3:0]       estado,
    output logic             busy,
    output logic             halted,
    output logic             illegal,
    output logic             timeout,
    output logic             pc_write,
    output logic [CNT_W-1:0] ciclos,
    output logic [CNT_W-1:0] instr_count
);

    typedef enum logic [3:0] {
        S_IF    = 4'b0000,
        S_ID    = 4'b0001,
        S_EX    = 4'b0010,
        S_MEM   = 4'b0011,
        S_WB    = 4'b0100,
        S_AUX1  = 4'b0101,
        S_AUX3  = 4'b0110,
        S_AUX4  = 4'b0111,
        S_SUMPC = 4'b1000,
        S_FIM   = 4'b1001,
        S_IDLE  = 4'b1010,
        S_AUX2  = 4'b1111
    } t_estado;

    localparam logic [6:0] OP_LOAD  = 7'b0000011;
    localparam logic [6:0] OP_STORE = 7'b0100011;
    localparam logic [6:0] OP_RTYPE = 7'b0110011;
    localparam logic [6:0] OP_IALU  = 7'b0010011;
    localparam logic [6:0] OP_BEQ   = 7'b1100011;

    localparam logic [CNT_W-1:0] ONE   = {{(CNT_W-1){1'b0}}, 1'b1};
    localparam logic [CNT_W-1:0] LIMIT = CNT_W'(MAX_INSTR);

    t_estado          r_state;
    t_estado          w_next;
    logic             r_step_d;
    logic             r_run_mode;
    logic [6:0]       r_opcode;
    logic             r_illegal;
    logic             r_timeout;
    logic [CNT_W-1:0] r_ciclos;
    logic [CNT_W-1:0] r_instr_count;

    logic             w_step_edge;
    logic             w_busy;
    logic             w_legal;
    logic             w_start;
    logic             w_start_run;
    logic             w_latch_op;
    logic             w_retire;
    logic             w_set_illegal;
    logic             w_set_timeout;
    logic [CNT_W-1:0] w_instr_inc;

    assign w_step_edge = step & ~r_step_d;
    assign w_busy      = (r_state != S_IDLE) && (r_state != S_FIM);
    assign w_legal     = (instrucao[6:0] == OP_LOAD)  || (instrucao[6:0] == OP_STORE) ||
                         (instrucao[6:0] == OP_RTYPE) || (instrucao[6:0] == OP_IALU)  ||
                         (instrucao[6:0] == OP_BEQ);
    assign w_instr_inc = (r_instr_count == '1) ? r_instr_count : r_instr_count + ONE;

    always_comb begin
        w_next        = r_state;
        w_start       = 1'b0;
        w_start_run   = 1'b0;
        w_latch_op    = 1'b0;
        w_retire      = 1'b0;
        w_set_illegal = 1'b0;
        w_set_timeout = 1'b0;
        case (r_state)
            S_IDLE: begin
                // run wins over a simultaneous step edge
                if (run) begin
                    w_next      = S_IF;
                    w_start     = 1'b1;
                    w_start_run = 1'b1;
                end else if (w_step_edge) begin
                    w_next  = S_IF;
                    w_start = 1'b1;
                end
            end
            S_IF: w_next = S_ID;
            S_ID: begin
                if (instrucao == 32'd0) begin
                    w_next = S_FIM;
                end else if (!w_legal) begin
                    w_next        = S_FIM;
                    w_set_illegal = 1'b1;
                end else begin
                    w_next     = S_EX;
                    w_latch_op = 1'b1;
                end
            end
            S_EX:   w_next = S_AUX1;
            S_AUX1: w_next = S_AUX2;
            S_AUX2: begin
                case (r_opcode)
                    OP_LOAD, OP_STORE: w_next = S_MEM;
                    OP_RTYPE, OP_IALU: w_next = S_WB;
                    OP_BEQ:            w_next = S_SUMPC;
                    default:           w_next = S_FIM;
                endcase
            end
            S_MEM:  w_next = (r_opcode == OP_STORE) ? S_SUMPC : S_WB;
            S_WB:   w_next = S_AUX3;
            S_AUX3: w_next = S_AUX4;
            S_AUX4: w_next = S_SUMPC;
            S_SUMPC: begin
                w_retire = 1'b1;
                if ((MAX_INSTR != 0) && (w_instr_inc == LIMIT)) begin
                    w_next        = S_FIM;
                    w_set_timeout = 1'b1;
                end else if (r_run_mode && run) begin
                    w_next = S_IF;
                end else begin
                    w_next = S_IDLE;
                end
            end
            S_FIM:   w_next = S_FIM;
            default: w_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            r_state       <= S_IDLE;
            r_step_d      <= 1'b0;
            r_run_mode    <= 1'b0;
            r_opcode      <= 7'd0;
            r_illegal     <= 1'b0;
            r_timeout     <= 1'b0;
            r_ciclos      <= '0;
            r_instr_count <= '0;
        end else begin
            r_state  <= w_next;
            // tracked every cycle so an edge seen while busy is simply lost
            r_step_d <= step;
            if (w_start)
                r_run_mode <= w_start_run;
            if (w_latch_op)
                r_opcode <= instrucao[6:0];
            if (w_set_illegal)
                r_illegal <= 1'b1;
            if (w_set_timeout)
                r_timeout <= 1'b1;
            if (w_busy && (r_ciclos != '1))
                r_ciclos <= r_ciclos + ONE;
            if (w_retire)
                r_instr_count <= w_instr_inc;
        end
    end

    assign estado      = r_state;
    assign busy        = w_busy;
    assign halted      = (r_state == S_FIM);
    assign illegal     = r_illegal;
    assign timeout     = r_timeout;
    assign pc_write    = (r_state == S_SUMPC);
    assign ciclos      = r_ciclos;
    assign instr_count = r_instr_count;

endmodule
